// File: rtl/weight_fifo_pkg.sv
// Shared types and constants for the weight FIFO that feeds the systolic array.
package weight_fifo_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ARRAY_N     = 32;
    localparam int unsigned TILE_ROWS   = 32;
    localparam int unsigned DEPTH_TILES = 2;
    localparam int unsigned DEPTH       = DEPTH_TILES * TILE_ROWS;

    localparam int unsigned ROW_W = ARRAY_N * DATA_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [ROW_W-1:0]              weight_row_t;
    typedef logic [$clog2(TILE_ROWS)-1:0]  tile_row_idx_t;
    typedef logic [PTR_W-1:0]              ptr_t;
    typedef logic [CNT_W-1:0]              count_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/weight_fifo_if.sv
// Row-write and weight-load handshake between host/control_unit and the weight FIFO.
interface weight_fifo_if;

    logic                           wr_valid;
    logic                           wr_ready;
    weight_fifo_pkg::weight_row_t   wr_data;
    logic                           load_weights;
    logic                           weight_fifo_valid;
    weight_fifo_pkg::weight_row_t   weight_row;
    logic                           weight_tile_last;

    modport master (
        output wr_valid,
        output wr_data,
        output load_weights,
        input  wr_ready,
        input  weight_fifo_valid,
        input  weight_row,
        input  weight_tile_last
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  load_weights,
        output wr_ready,
        output weight_fifo_valid,
        output weight_row,
        output weight_tile_last
    );

endinterface

// File: rtl/wf_row_ram.sv
// Simple dual-port row RAM: one write port, one registered read port, no array reset.
module wf_row_ram #(
    parameter int unsigned Depth = 64,
    parameter int unsigned Width = 256,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_fifo.sv
// Weight-tile FIFO: buffers host rows and streams exactly one tile per load_weights interval.
module weight_fifo
    import weight_fifo_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    weight_fifo_if.slave bus,
    input  logic  flush_i,
    output logic  next_weight_tile_rdy_o,
    output count_t count_o
);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $fatal(1, "weight_fifo: DEPTH must be a power of two");
    end

    localparam count_t        DepthCnt = count_t'(DEPTH);
    localparam count_t        TileCnt  = count_t'(TILE_ROWS);
    localparam tile_row_idx_t TileLast = tile_row_idx_t'(TILE_ROWS - 1);

    ptr_t          wr_ptr_q, wr_ptr_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    count_t        count_q, count_d;
    tile_row_idx_t tile_row_q, tile_row_d;
    logic          armed_q, armed_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          row_seen_q, row_seen_d;

    logic          wr_ready;
    logic          push;
    logic          pop;
    logic          tile_end;
    weight_row_t   ram_rdata;

    assign wr_ready = (count_q < DepthCnt);
    assign push     = bus.wr_valid & wr_ready & ~flush_i;
    // An empty FIFO never pops, so a same-cycle push is stored rather than bypassed.
    assign pop      = bus.load_weights & armed_q & (count_q != '0) & ~flush_i;
    assign tile_end = pop & (tile_row_q == TileLast);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tile_row_d = tile_row_q;
        armed_d    = armed_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        row_seen_d = row_seen_q | pop;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            tile_row_d = '0;
            armed_d    = 1'b1;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + ptr_t'(1);
                tile_row_d = tile_end ? '0 : tile_row_q + tile_row_idx_t'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + count_t'(1);
                2'b01:   count_d = count_q - count_t'(1);
                default: count_d = count_q;
            endcase
            // Once a tile completes, hold off until control_unit drops load_weights.
            if (tile_end) begin
                armed_d = 1'b0;
            end else if (!bus.load_weights) begin
                armed_d = 1'b1;
            end
            valid_d = pop;
            last_d  = tile_end;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tile_row_q <= '0;
            armed_q    <= 1'b1;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            row_seen_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tile_row_q <= tile_row_d;
            armed_q    <= armed_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            row_seen_q <= row_seen_d;
        end
    end

    wf_row_ram #(
        .Depth (DEPTH),
        .Width (ROW_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // The RAM read register is unreset; mask it until a row has actually been popped.
    assign bus.weight_row        = row_seen_q ? ram_rdata : '0;
    assign bus.weight_fifo_valid = valid_q;
    assign bus.weight_tile_last  = last_q;
    assign bus.wr_ready          = rst_ni & wr_ready;

    assign next_weight_tile_rdy_o = (count_q >= TileCnt);
    assign count_o                = count_q;

endmodule

// File: tb/tb_weight_fifo.sv
// Directed self-checking bench for weight_fifo.
module tb_weight_fifo;
    import weight_fifo_pkg::*;

    logic   clk = 1'b0;
    logic   rst_ni;
    logic   flush;
    logic   next_rdy;
    count_t count;

    int n_chk  = 0;
    int n_fail = 0;

    weight_fifo_if bus ();

    weight_fifo dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_ni),
        .bus                    (bus),
        .flush_i                (flush),
        .next_weight_tile_rdy_o (next_rdy),
        .count_o                (count)
    );

    always #5 clk = ~clk;

    function automatic weight_row_t mk_row(input int v);
        weight_row_t r;
        for (int k = 0; k < ARRAY_N; k++) begin
            r[k*DATA_W +: DATA_W] = DATA_W'(v + k);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input weight_row_t obs, input weight_row_t exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rows(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = mk_row(base + i);
            step();
        end
        bus.wr_valid = 1'b0;
    endtask

    // load_weights must already be high; checks one full tile then idle cycles.
    task automatic run_tile(input string tag, input int base, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            step();
            chk({tag, "_valid"}, weight_row_t'(bus.weight_fifo_valid), weight_row_t'(c < 32));
            if (c < 32) begin
                chk({tag, "_row"}, bus.weight_row, mk_row(base + c));
                chk({tag, "_last"}, weight_row_t'(bus.weight_tile_last), weight_row_t'(c == 31));
            end
        end
    endtask

    initial begin
        rst_ni           = 1'b0;
        flush            = 1'b0;
        bus.wr_valid     = 1'b0;
        bus.wr_data      = '0;
        bus.load_weights = 1'b0;
        #12;
        chk("rst_valid", weight_row_t'(bus.weight_fifo_valid), '0);
        chk("rst_count", weight_row_t'(count), '0);
        chk("rst_wr_ready", weight_row_t'(bus.wr_ready), '0);
        chk("rst_row", bus.weight_row, '0);
        step();
        rst_ni = 1'b1;
        #1;
        chk("post_rst_wr_ready", weight_row_t'(bus.wr_ready), 1);
        chk("post_rst_next_rdy", weight_row_t'(next_rdy), 0);

        // One tile, load held high past the tile.
        push_rows(0, 32);
        chk("t1_count", weight_row_t'(count), 32);
        chk("t1_next_rdy", weight_row_t'(next_rdy), 1);
        bus.load_weights = 1'b1;
        run_tile("t1", 0, 40);
        bus.load_weights = 1'b0;
        step();
        chk("t1_count_end", weight_row_t'(count), 0);

        // Two tiles separated by a one-cycle low on load_weights.
        push_rows(0, 64);
        chk("t2_count_full", weight_row_t'(count), 64);
        chk("t2_wr_ready_full", weight_row_t'(bus.wr_ready), 0);
        bus.load_weights = 1'b1;
        run_tile("t2a", 0, 40);
        bus.load_weights = 1'b0;
        step();
        chk("t2_gap_valid", weight_row_t'(bus.weight_fifo_valid), 0);
        bus.load_weights = 1'b1;
        run_tile("t2b", 32, 40);
        chk("t2_count_end", weight_row_t'(count), 0);
        bus.load_weights = 1'b0;
        step();

        // Underflow: rows trickle in every third cycle with load held high.
        bus.load_weights = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = mk_row(100 + i);
            step();
            bus.wr_valid = 1'b0;
            chk("t3_push_valid", weight_row_t'(bus.weight_fifo_valid), 0);
            step();
            chk("t3_valid", weight_row_t'(bus.weight_fifo_valid), 1);
            chk("t3_row", bus.weight_row, mk_row(100 + i));
            chk("t3_last", weight_row_t'(bus.weight_tile_last), weight_row_t'(i == 31));
            step();
            chk("t3_gap_valid", weight_row_t'(bus.weight_fifo_valid), 0);
        end
        chk("t3_count_end", weight_row_t'(count), 0);
        bus.load_weights = 1'b0;
        step();

        // Full: write with a same-cycle pop is dropped.
        push_rows(200, 64);
        chk("t4_wr_ready_full", weight_row_t'(bus.wr_ready), 0);
        bus.wr_valid     = 1'b1;
        bus.wr_data      = mk_row(7);
        bus.load_weights = 1'b1;
        step();
        chk("t4_count_drop", weight_row_t'(count), 63);
        chk("t4_valid", weight_row_t'(bus.weight_fifo_valid), 1);
        chk("t4_row", bus.weight_row, mk_row(200));
        bus.wr_valid     = 1'b0;
        bus.load_weights = 1'b0;
        step();
        chk("t4_count_hold", weight_row_t'(count), 63);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush_count", weight_row_t'(count), 0);
        chk("t4_flush_valid", weight_row_t'(bus.weight_fifo_valid), 0);

        // Half full: push+pop keeps count constant; the rest of the tile drains afterwards.
        push_rows(0, 32);
        bus.load_weights = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = mk_row(32 + j);
            step();
            chk("t4_pp_count", weight_row_t'(count), 32);
            chk("t4_pp_row", bus.weight_row, mk_row(j));
        end
        bus.wr_valid = 1'b0;
        for (int c = 0; c < 27; c++) begin
            step();
            chk("t4_drain_valid", weight_row_t'(bus.weight_fifo_valid), 1);
            chk("t4_drain_row", bus.weight_row, mk_row(5 + c));
            chk("t4_drain_last", weight_row_t'(bus.weight_tile_last), weight_row_t'(c == 26));
        end
        bus.load_weights = 1'b0;
        step();
        chk("t4_count_rest", weight_row_t'(count), 5);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Asynchronous reset after 10 beats of a tile.
        push_rows(10, 32);
        bus.load_weights = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t5_pre_row", bus.weight_row, mk_row(10 + c));
        end
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_valid", weight_row_t'(bus.weight_fifo_valid), 0);
        chk("t5_rst_count", weight_row_t'(count), 0);
        chk("t5_rst_row", bus.weight_row, '0);
        chk("t5_rst_next_rdy", weight_row_t'(next_rdy), 0);
        bus.load_weights = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
        chk("t5_rel_count", weight_row_t'(count), 0);
        chk("t5_rel_next_rdy", weight_row_t'(next_rdy), 0);
        chk("t5_rel_wr_ready", weight_row_t'(bus.wr_ready), 1);
        push_rows(70, 32);
        bus.load_weights = 1'b1;
        run_tile("t5", 70, 34);
        bus.load_weights = 1'b0;
        step();

        // Flush beats a simultaneous push and pop.
        push_rows(120, 40);
        chk("t6_count", weight_row_t'(count), 40);
        flush            = 1'b1;
        bus.wr_valid     = 1'b1;
        bus.wr_data      = mk_row(99);
        bus.load_weights = 1'b1;
        step();
        chk("t6_flush_count", weight_row_t'(count), 0);
        chk("t6_flush_valid", weight_row_t'(bus.weight_fifo_valid), 0);
        chk("t6_flush_last", weight_row_t'(bus.weight_tile_last), 0);
        flush            = 1'b0;
        bus.wr_valid     = 1'b0;
        bus.load_weights = 1'b0;
        step();
        chk("t6_count_after", weight_row_t'(count), 0);
        push_rows(5, 1);
        bus.load_weights = 1'b1;
        step();
        chk("t6_valid", weight_row_t'(bus.weight_fifo_valid), 1);
        chk("t6_row", bus.weight_row, mk_row(5));
        bus.load_weights = 1'b0;
        step();
        chk("t6_count_end", weight_row_t'(count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_fifo.md
Name: weight_fifo

Overview:
- Responder side of the weight-load handshake driven by control_unit.
- Buffers weight-tile rows written by the host/DMA side.
- Streams exactly one tile (TILE_ROWS rows) per load_weights request into the systolic array, flagging each delivered row with weight_fifo_valid_o.
- control_unit counts these valid beats to leave LOAD_WEIGHTS; this block guarantees a tile never over-delivers even though load_weights stays high through LOAD_ACTIVATIONS.

Parameters:
- DATA_W, 8, bits per weight element.
- ARRAY_N, 32, elements per row (systolic array width).
- TILE_ROWS, 32, rows per weight tile.
- DEPTH_TILES, 2, tiles of storage; total depth D = DEPTH_TILES*TILE_ROWS rows.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- wr_valid_i  in  1  host row write request.
- wr_ready_o  out  1  FIFO can accept a row this cycle.
- wr_data_i  in  ARRAY_N*DATA_W  row to store.
- load_weights_i  in  1  pop request level from control_unit.
- weight_fifo_valid_o  out  1  weight_row_o carries a delivered row this cycle.
- weight_row_o  out  ARRAY_N*DATA_W  delivered row.
- weight_tile_last_o  out  1  current valid row is row TILE_ROWS-1 of the tile.
- next_weight_tile_rdy_o  out  1  at least TILE_ROWS rows stored.
- flush_i  in  1  synchronous clear of contents and tile state.
- count_o  out  $clog2(D+1)  stored row count.

Behaviour:
- Reset (rst_ni low, asynchronous): pointers, count and tile row counter are 0; tile_armed is 1.
  - All outputs read 0 during reset, except wr_ready_o, which reads 1 once reset deasserts.
- Storage: circular buffer of D rows.
  - Read and write pointers are $clog2(D) bits and wrap from D-1 to 0.
  - D must be a power of two; enforce with an elaboration assertion.
- Write rules:
  - A push occurs when wr_valid_i && wr_ready_o.
  - wr_ready_o = (count < D), decoded from registered count.
  - A write when full is dropped, with no state change.
- Pop rules:
  - A pop occurs when load_weights_i && tile_armed && (count != 0).
  - A pop increments the read pointer and the tile row counter.
- Output timing: registered, latency 1.
  - The cycle after a pop: weight_fifo_valid_o = 1 and weight_row_o = the popped row.
  - weight_tile_last_o = 1 when that pop was tile row TILE_ROWS-1.
  - Otherwise valid and last are 0; weight_row_o holds its last value.
- Tile gating:
  - When the pop of row TILE_ROWS-1 occurs, the tile row counter returns to 0 and tile_armed clears.
  - Further pops are blocked while load_weights_i stays high.
  - tile_armed sets again in the first cycle in which load_weights_i is sampled low.
  - Result: exactly TILE_ROWS valid beats per load_weights high interval.
- Underflow: a pop request while empty produces a stall (valid 0).
  - The tile counter holds, and delivery resumes as rows arrive.
  - Beats within a tile may be non-contiguous.
- Simultaneous push and pop:
  - Both proceed; count is unchanged.
  - When empty, the push is stored and the pop is not performed (no bypass).
  - When full, wr_ready_o is 0 that cycle, so no push occurs even though a pop frees a slot.
- next_weight_tile_rdy_o = (count >= TILE_ROWS), combinational from registered count.
- flush_i:
  - Clears pointers, count and tile counter, and sets tile_armed.
  - Next-cycle valid and last are 0.
  - flush_i has priority over a simultaneous push or pop in the same cycle.
- Reset mid-tile: a partial tile is discarded, and the next tile starts at row 0.

Decomposition:
- Shared package Weight_types, alongside Acc_types, holding:
  - DATA_W, ARRAY_N, TILE_ROWS constants;
  - typedef weight_row_t (logic [ARRAY_N*DATA_W-1:0]);
  - typedef tile_row_idx_t (logic [$clog2(TILE_ROWS)-1:0]).
- One sub-module, wf_row_ram:
  - simple dual-port RAM, D x row width;
  - one write port, one registered read port;
  - no reset on the array, so it infers block RAM.
- Pointer, count and tile logic stay in weight_fifo.

Test Plan:
- Reset then write 32 rows (values 0..31), hold load_weights_i high 40 cycles.
  - Expect exactly 32 valid beats, rows 0..31 in order, first beat 1 cycle after the first pop.
  - Expect last=1 only on row 31; valid=0 for the remaining cycles.
- Write 64 rows, pulse load_weights_i high 40 cycles, low 1 cycle, high 40 cycles.
  - Expect two tiles of 32 beats: rows 0..31, then 32..63.
  - Expect count_o = 0 at the end.
- Empty FIFO with load_weights_i high; write one row every 3 cycles.
  - Expect each row delivered 1 cycle after its pop, with 32 non-contiguous beats and last on the 32nd.
- Fill to 64 rows; assert wr_valid_i with one pop in the same cycle.
  - Expect wr_ready_o = 0, write dropped, count_o = 63 next cycle.
  - Then push+pop on a half-full FIFO holds count_o constant.
- After 10 beats of a tile, drop rst_ni asynchronously mid-cycle.
  - Expect outputs 0 immediately; after release, count_o = 0 and next_weight_tile_rdy_o = 0.
  - A new 32-row tile is delivered from row index 0.
- With 40 rows stored, assert flush_i together with wr_valid_i and a pop.
  - Expect count_o = 0 next cycle, valid = 0, and no row from that cycle stored.
